// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer: FSM states, opcode
// field bounds and the opcodes the sequencer itself has to recognise.
package fetch_pkg;

  typedef enum logic [2:0] {
    S_RESET,
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_BRANCH,
    S_HALT
  } state_t;

  localparam int unsigned OPC_HI = 15;
  localparam int unsigned OPC_LO = 12;

  localparam logic [3:0] OP_JR   = 4'hA;
  localparam logic [3:0] OP_JA   = 4'hB;
  localparam logic [3:0] OP_JREG = 4'hC;
  localparam logic [3:0] OP_BRZ  = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hF;

  function automatic logic is_branch(input logic [3:0] opc);
    return (opc == OP_JR) || (opc == OP_JA) || (opc == OP_JREG) || (opc == OP_BRZ);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory-wait cycles; expired marks the last permitted one.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = $clog2(MEM_TIMEOUT);
  localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-side controller: reads instructions, hands them to execute over
// valid/ready and steers the addressing unit's PC-source selects.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] DataBus,
  input  logic        memDataReady,
  input  logic        ir_ready,
  input  logic        cond_z,
  output logic        ReadMem,
  output logic [15:0] IR,
  output logic [7:0]  Iside,
  output logic        ir_valid,
  output logic        ResetPC,
  output logic        PCplusI,
  output logic        PCplus1,
  output logic        Iplus0,
  output logic        Rplus0,
  output logic        PCenable,
  output logic        halted,
  output logic        fault
);

  state_t      state;
  state_t      state_next;
  logic [3:0]  opcode;
  logic        load_ir;
  logic        set_fault;
  logic        timer_clear;
  logic        timer_enable;
  logic        timer_expired;

  assign opcode = IR[OPC_HI:OPC_LO];
  assign Iside  = IR[7:0];

  assign timer_clear  = (state == S_FETCH);
  assign timer_enable = (state == S_WAIT) && !memDataReady;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expired(timer_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RESET;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    ReadMem    = 1'b0;
    ResetPC    = 1'b0;
    PCplusI    = 1'b0;
    PCplus1    = 1'b0;
    Iplus0     = 1'b0;
    Rplus0     = 1'b0;
    PCenable   = 1'b0;
    load_ir    = 1'b0;
    set_fault  = 1'b0;

    unique case (state)
      S_RESET: begin
        ResetPC    = 1'b1;
        PCenable   = 1'b1;
        state_next = S_FETCH;
      end
      S_FETCH: begin
        ReadMem    = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        ReadMem = 1'b1;
        // A word arriving on the last permitted cycle still beats the timeout.
        if (memDataReady) begin
          load_ir    = 1'b1;
          PCplus1    = 1'b1;
          PCenable   = 1'b1;
          state_next = S_ISSUE;
        end else if (timer_expired) begin
          set_fault  = 1'b1;
          state_next = S_HALT;
        end
      end
      S_ISSUE: begin
        if (ir_ready) begin
          if (opcode == OP_HALT) begin
            state_next = S_HALT;
          end else if (is_branch(opcode)) begin
            state_next = S_BRANCH;
          end else begin
            state_next = S_FETCH;
          end
        end
      end
      S_BRANCH: begin
        state_next = S_FETCH;
        case (opcode)
          OP_JR: begin
            PCplusI  = 1'b1;
            PCenable = 1'b1;
          end
          OP_JA: begin
            Iplus0   = 1'b1;
            PCenable = 1'b1;
          end
          OP_JREG: begin
            Rplus0   = 1'b1;
            PCenable = 1'b1;
          end
          OP_BRZ: begin
            PCplusI  = cond_z;
            PCenable = cond_z;
          end
          default: ;
        endcase
      end
      S_HALT: ;
      default: state_next = S_RESET;
    endcase

    // Reset overrides the decode so the PC is cleared from the very first cycle.
    if (rst) begin
      ReadMem  = 1'b0;
      ResetPC  = 1'b1;
      PCplusI  = 1'b0;
      PCplus1  = 1'b0;
      Iplus0   = 1'b0;
      Rplus0   = 1'b0;
      PCenable = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      IR       <= '0;
      ir_valid <= 1'b0;
      halted   <= 1'b0;
      fault    <= 1'b0;
    end else begin
      if (load_ir) begin
        IR       <= DataBus;
        ir_valid <= 1'b1;
      end else if ((state == S_ISSUE) && ir_ready) begin
        ir_valid <= 1'b0;
      end
      if (set_fault) begin
        fault <= 1'b1;
      end
      if (state_next == S_HALT) begin
        halted <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed sequences, a branch vector table and
// randomized programs checked against an instruction-level reference model.
module tb_fetch_sequencer;

  localparam logic [15:0] RSIDE = 16'h0030;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] DataBus;
  logic        memDataReady;
  logic        ir_ready;
  logic        cond_z;
  logic        ReadMem;
  logic [15:0] IR;
  logic [7:0]  Iside;
  logic        ir_valid;
  logic        ResetPC, PCplusI, PCplus1, Iplus0, Rplus0, PCenable;
  logic        halted;
  logic        fault;

  int errors = 0;
  int checks = 0;

  // Stimulus control set by the main sequence, applied by the responder.
  int          mem_mode = 0;
  int          lat = 0;
  logic        rdy_mode = 1'b0;
  logic        z_mode = 1'b0;
  logic        man_ready = 1'b0;
  logic        man_z = 1'b0;
  logic        rand_ready;
  logic        rand_z;

  logic [15:0] mem [256];
  logic        zbits [64];
  logic [15:0] pc_m = '0;
  int          n_issued = 0;
  logic [15:0] got_q [$];
  logic [15:0] exp_q [$];

  logic [4:0]  sel;
  assign sel      = {ResetPC, PCplusI, PCplus1, Iplus0, Rplus0};
  assign ir_ready = rdy_mode ? rand_ready : man_ready;
  assign cond_z   = z_mode ? rand_z : man_z;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .MEM_TIMEOUT(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .DataBus     (DataBus),
    .memDataReady(memDataReady),
    .ir_ready    (ir_ready),
    .cond_z      (cond_z),
    .ReadMem     (ReadMem),
    .IR          (IR),
    .Iside       (Iside),
    .ir_valid    (ir_valid),
    .ResetPC     (ResetPC),
    .PCplusI     (PCplusI),
    .PCplus1     (PCplus1),
    .Iplus0      (Iplus0),
    .Rplus0      (Rplus0),
    .PCenable    (PCenable),
    .halted      (halted),
    .fault       (fault)
  );

  // Addressing unit model plus handshake scoreboard.
  always @(posedge clk) begin
    if (PCenable) begin
      if (ResetPC)      pc_m <= 16'h0000;
      else if (PCplus1) pc_m <= pc_m + 16'd1;
      else if (PCplusI) pc_m <= pc_m + {{8{Iside[7]}}, Iside};
      else if (Iplus0)  pc_m <= {8'h00, Iside};
      else if (Rplus0)  pc_m <= RSIDE;
    end
    if (rst) begin
      n_issued <= 0;
      got_q.delete();
    end else if (ir_valid && ir_ready) begin
      n_issued <= n_issued + 1;
      got_q.push_back(IR);
    end
  end

  // Memory and execute-side responder, driven just after each rising edge.
  initial begin
    int rm_cnt;
    int miss;
    rm_cnt = 0;
    miss = 0;
    memDataReady = 1'b0;
    DataBus = '0;
    rand_ready = 1'b0;
    rand_z = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      DataBus = mem[pc_m[7:0]];
      rm_cnt = ReadMem ? rm_cnt + 1 : 0;
      case (mem_mode)
        1: memDataReady = ReadMem;
        2: begin
          memDataReady = ReadMem && ((miss >= 2) || ($urandom_range(0, 2) != 0));
          miss = (ReadMem && !memDataReady) ? miss + 1 : 0;
        end
        3: memDataReady = ReadMem && (rm_cnt == lat);
        default: memDataReady = 1'b0;
      endcase
      rand_ready = 1'($urandom_range(0, 1));
      rand_z = zbits[n_issued % 64];
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_issued(input int n, input string name);
    int cyc;
    cyc = 0;
    while (n_issued < n && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    check(name, 32'(n_issued >= n), 32'd1);
  endtask

  // Instruction-level model: the sequence of words handed to execute.
  task automatic build_model(input int n_max);
    logic [15:0] pc;
    logic [15:0] ins;
    logic [15:0] sx;
    exp_q.delete();
    pc = 16'h0000;
    for (int k = 0; k < n_max; k++) begin
      ins = mem[pc[7:0]];
      pc = pc + 16'd1;
      exp_q.push_back(ins);
      sx = {{8{ins[7]}}, ins[7:0]};
      if (ins[15:12] == 4'hF) break;
      case (ins[15:12])
        4'hA: pc = pc + sx;
        4'hB: pc = {8'h00, ins[7:0]};
        4'hC: pc = RSIDE;
        4'hD: if (zbits[k + 1]) pc = pc + sx;
        default: ;
      endcase
    end
  endtask

  typedef struct {
    logic [15:0] instr;
    logic        z;
    logic        en;
    logic [4:0]  sel;
    logic        rm;
    logic [15:0] pc;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int cyc;
    vecs[0] = '{16'hA0FE, 1'b0, 1'b1, 5'b01000, 1'b0, 16'h000E};
    vecs[1] = '{16'hB040, 1'b0, 1'b1, 5'b00010, 1'b0, 16'h0040};
    vecs[2] = '{16'hC000, 1'b0, 1'b1, 5'b00001, 1'b0, 16'h0030};
    vecs[3] = '{16'hD005, 1'b0, 1'b0, 5'b00000, 1'b0, 16'h0010};
    vecs[4] = '{16'hD005, 1'b1, 1'b1, 5'b01000, 1'b0, 16'h0015};
    vecs[5] = '{16'hD0FB, 1'b1, 1'b1, 5'b01000, 1'b0, 16'h000B};
    vecs[6] = '{16'h1234, 1'b1, 1'b0, 5'b00000, 1'b1, 16'h0010};
    vecs[7] = '{16'hE0FF, 1'b0, 1'b0, 5'b00000, 1'b1, 16'h0010};
    vecs[8] = '{16'hA07F, 1'b0, 1'b1, 5'b01000, 1'b0, 16'h008F};
    vecs[9] = '{16'hB0FF, 1'b0, 1'b1, 5'b00010, 1'b0, 16'h00FF};

    for (int a = 0; a < 256; a++) mem[a] = '0;
    for (int a = 0; a < 64; a++) zbits[a] = 1'b0;

    // Reset held, then first fetch and backpressure.
    rst = 1'b1;
    mem[0] = 16'h1234;
    mem_mode = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_ctl", 32'({sel, PCenable, ReadMem}), 32'b1000010);
      check("rst_regs", 32'({ir_valid, halted, fault, IR}), 32'd0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_state_ctl", 32'({sel, PCenable, ReadMem}), 32'b1000010);
    @(negedge clk);
    check("fetch_readmem", 32'({sel, PCenable, ReadMem}), 32'b0000001);
    @(negedge clk);
    check("wait_pcplus1", 32'({sel, PCenable, ReadMem}), 32'b0010011);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_ir", 32'(IR), 32'h1234);
      check("bp_ctl", 32'({ir_valid, PCenable, ReadMem}), 32'b100);
    end
    check("pc_after_fetch", 32'(pc_m), 32'h0001);
    man_ready = 1'b1;
    @(negedge clk);
    check("release_fetch", 32'({ir_valid, ReadMem}), 32'b01);

    // Branch / dispatch vector table, each from PC 0x0010 after increment.
    mem_mode = 1;
    mem[0] = 16'hB00F;
    for (int v = 0; v < 10; v++) begin
      mem[15] = vecs[v].instr;
      man_z = vecs[v].z;
      man_ready = 1'b1;
      do_reset(2);
      wait_issued(2, "vec_issue");
      check($sformatf("vec%0d_ctl", v), 32'({PCenable, sel, ReadMem}),
            32'({vecs[v].en, vecs[v].sel, vecs[v].rm}));
      @(negedge clk);
      check($sformatf("vec%0d_pc", v), 32'(pc_m), 32'(vecs[v].pc));
    end

    // Timeout without ready: fault on the 4th WAIT cycle.
    @(negedge clk);
    mem_mode = 0;
    man_ready = 1'b0;
    do_reset(2);
    repeat (6) @(negedge clk);
    check("to_last_wait", 32'({fault, halted, ReadMem}), 32'b001);
    @(negedge clk);
    check("to_fault", 32'({fault, halted, ReadMem, PCenable}), 32'b1100);
    repeat (3) @(negedge clk);
    check("to_stays", 32'({fault, halted, ReadMem, PCenable}), 32'b1100);

    // Ready on the 4th WAIT cycle is accepted.
    mem[0] = 16'h2345;
    mem_mode = 3;
    lat = 5;
    do_reset(2);
    repeat (6) @(negedge clk);
    check("late_ready_ctl", 32'({sel, PCenable, fault}), 32'b0010010);
    @(negedge clk);
    check("late_ready_ir", 32'({ir_valid, fault, halted, IR}), 32'({3'b100, 16'h2345}));

    // HALT instruction, then reset restarts from PC 0.
    @(negedge clk);
    mem[0] = 16'hF000;
    mem_mode = 1;
    man_ready = 1'b1;
    do_reset(2);
    wait_issued(1, "halt_issue");
    check("halt_now", 32'({halted, ir_valid, ReadMem}), 32'b100);
    repeat (4) @(negedge clk);
    check("halt_stays", 32'({halted, ReadMem, PCenable, fault}), 32'b1000);
    mem[0] = 16'h1111;
    do_reset(2);
    @(negedge clk);
    check("restart_reset", 32'({halted, ResetPC, PCenable}), 32'b011);
    @(negedge clk);
    check("restart_fetch", 32'({ReadMem, pc_m}), 32'({1'b1, 16'h0000}));

    // Randomized programs against the reference model.
    for (int ep = 0; ep < 10; ep++) begin
      @(negedge clk);
      for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);
      for (int a = 0; a < 64; a++) zbits[a] = 1'($urandom_range(0, 1));
      build_model(30);
      mem_mode = 2;
      rdy_mode = 1'b1;
      z_mode = 1'b1;
      do_reset(2);
      cyc = 0;
      while (got_q.size() < exp_q.size() && cyc < 2000) begin
        @(negedge clk);
        check("sel_onehot", 32'($countones(sel) <= 1), 32'd1);
        cyc++;
      end
      check("ep_done", 32'(got_q.size() >= exp_q.size()), 32'd1);
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        check($sformatf("ep%0d_ir%0d", ep, i), 32'(got_q[i]), 32'(exp_q[i]));
      end
      if (exp_q[$][15:12] == 4'hF) begin
        @(negedge clk);
        check("ep_halt", 32'({halted, ReadMem}), 32'b10);
      end
      check("ep_no_fault", 32'(fault), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
